// File: rtl/feedback_arbiter_pkg.sv
// feedback_arbiter_pkg
//   Shared types and constants for the player-feedback arbiter: colour width,
//   timer width, tone codes, FSM state encoding and colour decode helpers.
package feedback_arbiter_pkg;

  localparam int COLOR_W = 2;
  localparam int TIMER_W = 10;
  localparam int STEP_W  = 3;

  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [TIMER_W-1:0] ticks_t;
  typedef logic [STEP_W-1:0]  step_t;

  localparam logic [2:0] TONE_OFF  = 3'd0;
  localparam logic [2:0] TONE_WIN  = 3'd5;
  localparam logic [2:0] TONE_LOSE = 3'd6;

  // Win runs steps 0..7 (all lit); lose runs steps 0..5 (lit on even steps).
  localparam step_t WIN_LAST_STEP  = 3'd7;
  localparam step_t LOSE_LAST_STEP = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP,
    ST_ANIM_ON,
    ST_ANIM_OFF
  } state_e;

  function automatic logic [3:0] color_led(input color_t c);
    return 4'b0001 << c;
  endfunction

  // Colour tones occupy codes 1..4.
  function automatic logic [2:0] color_tone(input color_t c);
    return {1'b0, c} + 3'd1;
  endfunction

endpackage

// File: rtl/feedback_arbiter_if.sv
// feedback_arbiter_if
//   Request/response bundle between the game controller side (master) and the
//   feedback arbiter (slave).
//   master drives: PB_REQ/PB_COLOR, EC_REQ/EC_COLOR, EV_REQ/EV_KIND
//   slave drives : PB_DONE, EV_DONE, LED[3:0], TONE[2:0], BUSY
interface feedback_arbiter_if;
  import feedback_arbiter_pkg::*;

  logic       PB_REQ;
  color_t     PB_COLOR;
  logic       PB_DONE;
  logic       EC_REQ;
  color_t     EC_COLOR;
  logic       EV_REQ;
  logic       EV_KIND;
  logic       EV_DONE;
  logic [3:0] LED;
  logic [2:0] TONE;
  logic       BUSY;

  modport master (
    output PB_REQ, PB_COLOR, EC_REQ, EC_COLOR, EV_REQ, EV_KIND,
    input  PB_DONE, EV_DONE, LED, TONE, BUSY
  );

  modport slave (
    input  PB_REQ, PB_COLOR, EC_REQ, EC_COLOR, EV_REQ, EV_KIND,
    output PB_DONE, EV_DONE, LED, TONE, BUSY
  );

endinterface

// File: rtl/feedback_timer.sv
// feedback_timer
//   Loadable TICK down-counter. LOAD with N arms an N-TICK interval; EXPIRE
//   pulses on the TICK that arrives while the count is 0.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   TICK         : single-cycle time-base strobe
//   LOAD         : load LOAD_VAL (interval length, 1..1023); wins over TICK
//   LOAD_VAL     : interval length in TICKs
//   EXPIRE       : one-cycle expiry strobe
module feedback_timer
  import feedback_arbiter_pkg::*;
(
  input  logic   CLK,
  input  logic   RST_N,
  input  logic   TICK,
  input  logic   LOAD,
  input  ticks_t LOAD_VAL,
  output logic   EXPIRE
);

  ticks_t count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (LOAD) begin
      count <= LOAD_VAL - ticks_t'(1);
    end else if (TICK && (count != '0)) begin
      count <= count - ticks_t'(1);
    end
  end

  // Free-running at 0 outside a slot; the arbiter ignores EXPIRE in IDLE.
  assign EXPIRE = TICK && (count == '0);

endmodule

// File: rtl/feedback_arbiter.sv
// feedback_arbiter
//   Arbitrates the LEDs and tone generator among end-of-game animations (EV),
//   press echo (EC) and sequence playback (PB), priority EV > EC > PB, and
//   times each grant in TICK units.
//   CLK, RST_N : clock, asynchronous active-low reset
//   TICK       : 1 kHz single-cycle strobe
//   bus        : request/done/LED/TONE/BUSY bundle (slave side)
module feedback_arbiter
  import feedback_arbiter_pkg::*;
#(
  parameter int ON_TICKS   = 300,
  parameter int GAP_TICKS  = 100,
  parameter int ECHO_TICKS = 150,
  parameter int ANIM_TICKS = 120
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic TICK,
  feedback_arbiter_if.slave bus
);

  localparam ticks_t ON_LOAD   = ticks_t'(ON_TICKS);
  localparam ticks_t GAP_LOAD  = ticks_t'(GAP_TICKS);
  localparam ticks_t ECHO_LOAD = ticks_t'(ECHO_TICKS);
  localparam ticks_t ANIM_LOAD = ticks_t'(ANIM_TICKS);

  state_e state_q, state_d;
  color_t color_q, color_d;
  logic   slot_is_ec_q, slot_is_ec_d;   // 0: playback slot, 1: echo slot
  logic   kind_q, kind_d;               // 0: win, 1: lose
  step_t  step_q, step_d;
  logic   pb_done_q, pb_done_d;
  logic   ev_done_q, ev_done_d;

  logic   pb_pend_q, ec_pend_q, ev_pend_q;
  color_t pb_color_q, ec_color_q;
  logic   ev_kind_q;
  logic   grant_pb, grant_ec, grant_ev;

  logic   tmr_load, tmr_expire;
  ticks_t tmr_val;

  logic   echo_active, in_anim;
  logic [3:0] led;
  logic [2:0] tone;

  assign echo_active = ((state_q == ST_ON) || (state_q == ST_GAP)) && slot_is_ec_q;
  assign in_anim     = (state_q == ST_ANIM_ON) || (state_q == ST_ANIM_OFF);

  feedback_timer u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .TICK     (TICK),
    .LOAD     (tmr_load),
    .LOAD_VAL (tmr_val),
    .EXPIRE   (tmr_expire)
  );

  // Single-entry pending latches. A request meeting its own set latch is
  // dropped, so the first colour wins. An echo request during an echo slot
  // retriggers the slot directly, and an animation request during an
  // animation is discarded.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pb_pend_q  <= 1'b0;
      pb_color_q <= '0;
      ec_pend_q  <= 1'b0;
      ec_color_q <= '0;
      ev_pend_q  <= 1'b0;
      ev_kind_q  <= 1'b0;
    end else begin
      if (grant_pb) begin
        pb_pend_q <= 1'b0;
      end else if (bus.PB_REQ && !pb_pend_q) begin
        pb_pend_q  <= 1'b1;
        pb_color_q <= bus.PB_COLOR;
      end
      if (grant_ec) begin
        ec_pend_q <= 1'b0;
      end else if (bus.EC_REQ && !ec_pend_q && !echo_active) begin
        ec_pend_q  <= 1'b1;
        ec_color_q <= bus.EC_COLOR;
      end
      if (grant_ev) begin
        ev_pend_q <= 1'b0;
      end else if (bus.EV_REQ && !ev_pend_q && !in_anim) begin
        ev_pend_q <= 1'b1;
        ev_kind_q <= bus.EV_KIND;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      color_q      <= '0;
      slot_is_ec_q <= 1'b0;
      kind_q       <= 1'b0;
      step_q       <= '0;
      pb_done_q    <= 1'b0;
      ev_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      color_q      <= color_d;
      slot_is_ec_q <= slot_is_ec_d;
      kind_q       <= kind_d;
      step_q       <= step_d;
      pb_done_q    <= pb_done_d;
      ev_done_q    <= ev_done_d;
    end
  end

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    color_d      = color_q;
    slot_is_ec_d = slot_is_ec_q;
    kind_d       = kind_q;
    step_d       = step_q;
    pb_done_d    = 1'b0;
    ev_done_d    = 1'b0;
    grant_pb     = 1'b0;
    grant_ec     = 1'b0;
    grant_ev     = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = ANIM_LOAD;

    case (state_q)
      ST_IDLE, ST_ON, ST_GAP: begin
        if (ev_pend_q) begin
          // Grant from IDLE, or preempt a slot; an aborted playback slot
          // still reports completion.
          grant_ev  = 1'b1;
          state_d   = ST_ANIM_ON;
          kind_d    = ev_kind_q;
          step_d    = '0;
          tmr_load  = 1'b1;
          tmr_val   = ANIM_LOAD;
          pb_done_d = (state_q != ST_IDLE) && !slot_is_ec_q;
        end else if (state_q == ST_IDLE) begin
          if (ec_pend_q) begin
            grant_ec     = 1'b1;
            state_d      = ST_ON;
            color_d      = ec_color_q;
            slot_is_ec_d = 1'b1;
            tmr_load     = 1'b1;
            tmr_val      = ECHO_LOAD;
          end else if (pb_pend_q) begin
            grant_pb     = 1'b1;
            state_d      = ST_ON;
            color_d      = pb_color_q;
            slot_is_ec_d = 1'b0;
            tmr_load     = 1'b1;
            tmr_val      = ON_LOAD;
          end
        end else if (slot_is_ec_q && bus.EC_REQ) begin
          state_d  = ST_ON;
          color_d  = bus.EC_COLOR;
          tmr_load = 1'b1;
          tmr_val  = ECHO_LOAD;
        end else if (tmr_expire) begin
          if (state_q == ST_ON) begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
          end else begin
            state_d   = ST_IDLE;
            pb_done_d = !slot_is_ec_q;
          end
        end
      end

      ST_ANIM_ON, ST_ANIM_OFF: begin
        if (tmr_expire) begin
          if (step_q == (kind_q ? LOSE_LAST_STEP : WIN_LAST_STEP)) begin
            state_d   = ST_IDLE;
            ev_done_d = 1'b1;
          end else begin
            step_d   = step_q + step_t'(1);
            tmr_load = 1'b1;
            tmr_val  = ANIM_LOAD;
            state_d  = (kind_q && (state_q == ST_ANIM_ON)) ? ST_ANIM_OFF : ST_ANIM_ON;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset darkens them immediately.
  always_comb begin
    led  = '0;
    tone = TONE_OFF;
    case (state_q)
      ST_ON: begin
        led  = color_led(color_q);
        tone = color_tone(color_q);
      end
      ST_ANIM_ON: begin
        if (kind_q) begin
          led  = 4'hF;
          tone = TONE_LOSE;
        end else begin
          led  = color_led(step_q[COLOR_W-1:0]);
          tone = TONE_WIN;
        end
      end
      default: ;
    endcase
  end

  assign bus.LED     = led;
  assign bus.TONE    = tone;
  assign bus.PB_DONE = pb_done_q;
  assign bus.EV_DONE = ev_done_q;
  assign bus.BUSY    = (state_q != ST_IDLE) || pb_pend_q || ec_pend_q || ev_pend_q;

endmodule

// File: doc/feedback_arbiter.md
# feedback_arbiter

Owns the shared player-feedback resources: the four colour LEDs and the tone generator select. It arbitrates among three requesters: sequence playback from the game controller, echo of player presses, and win/lose end-of-game animations. It sequences each grant through timed on/gap phases counted in external TICK strobes, and returns completion pulses so the game controller can pace playback and end-of-game handling.

## Interface
- ON_TICKS, 300: playback LED-on duration in TICKs; legal range 1..1023.
- GAP_TICKS, 100: dark gap after playback or echo; legal range 1..1023.
- ECHO_TICKS, 150: echo LED-on duration; legal range 1..1023.
- ANIM_TICKS, 120: duration of each animation step; legal range 1..1023.
- CLK  in  1  clock.
- RST_N  in  1  asynchronous, active-low reset.
- TICK  in  1  1 kHz single-cycle strobe.
- PB_REQ  in  1  playback request pulse.
- PB_COLOR  in  2  colour for playback, sampled with PB_REQ.
- PB_DONE  out  1  one-cycle pulse when a playback slot ends or is aborted.
- EC_REQ  in  1  echo request pulse, issued on a valid press.
- EC_COLOR  in  2  colour for echo, sampled with EC_REQ.
- EV_REQ  in  1  animation request pulse.
- EV_KIND  in  1  animation type: 0 = win, 1 = lose.
- EV_DONE  out  1  one-cycle pulse at the end of an animation.
- LED  out  4  LED drive; one-hot `1<<color`, or 4'hF for all on.
- TONE  out  3  tone select: 0 = silent, 1–4 = colour 0–3, 5 = win, 6 = lose.
- BUSY  out  1  high whenever state ≠ IDLE or any request is pending.

## Operation
- Each requester has a single-entry pending latch with a colour or kind register.
  - A request pulse sets its latch at the clock edge.
  - A request that arrives while its own latch is already set is dropped; the first colour is kept.
- Arbitration happens only in IDLE. Priority is fixed: EV > EC > PB. A grant clears that requester's latch.
- States and transitions:
  - IDLE: on a grant, load the timer.
    - EV grant → ANIM_ON, step = 0.
    - EC grant → ON with ECHO_TICKS.
    - PB grant → ON with ON_TICKS.
  - ON: LED = `1<<color`, TONE = color + 1. On timer expiry → GAP, loaded with GAP_TICKS.
  - GAP: LED = 0, TONE = 0. On expiry → IDLE. If the slot was a playback slot, pulse PB_DONE.
  - ANIM_ON, win: LED = `1<<step[1:0]`, TONE = 5.
  - ANIM_ON, lose: LED = 4'hF, TONE = 6.
  - ANIM_OFF: lose only, all outputs dark.
  - Step advance: each step lasts ANIM_TICKS.
    - Win runs 8 steps, ANIM_ON only.
    - Lose runs 6 steps, alternating ANIM_ON / ANIM_OFF.
    - After the last step → IDLE and pulse EV_DONE.
- Preemption:
  - EV_REQ during an ON or GAP slot aborts that slot. Next cycle the block enters ANIM_ON directly.
  - If the aborted slot was playback, PB_DONE pulses in the abort cycle so the controller never hangs.
  - EV_REQ during an animation is dropped.
- Retrigger: EC_REQ during an echo slot (ON or GAP) restarts ON with the new colour and reloads ECHO_TICKS. The echo latch is not used in this case.
- EC_REQ during a playback slot is latched and served after the slot ends.
- Timer arithmetic:
  - 10-bit down-counter, loaded with N−1.
  - Decrements only on TICK.
  - Expires on the TICK that arrives when the count is 0.
- Step counter is 3 bits and does not wrap: the 8th win step is terminal.

## Timing
- Reset values: LED = 0, TONE = 0, BUSY = 0, PB_DONE = 0, EV_DONE = 0. State = IDLE, all latches cleared, timer = 0.
- Reset asserted mid-slot: outputs go dark immediately. No DONE pulse is issued.
- Grant latency: a request at edge k is latched at k. The IDLE grant happens at k+1, so LED/TONE are valid after edge k+1. Total latency is 2 cycles from request to visible LED.
- ON duration is exactly N TICK strobes, ±1 cycle of phase.
- PB_DONE asserts the cycle after the GAP expiry edge, coincident with the return to IDLE.
- Back-to-back requests: PB_REQ issued in the same cycle as PB_DONE is latched and granted with no extra idle cycle.
- Simultaneous EV, EC and PB requests in IDLE: EV is served. EC and PB stay latched and are served afterwards in priority order.

## Structure
- Shared package: tone codes (TONE_OFF, TONE_WIN, TONE_LOSE), the state enum, and the colour width.
- One sub-module, `feedback_timer`: a loadable 10-bit TICK down-counter with a LOAD input and a one-cycle EXPIRE output. The arbiter FSM, latches and step counter live in the top level.

## Test plan
- Set ON_TICKS = 3, GAP_TICKS = 2. Send PB_REQ with colour 2 → LED = 4'b0100 and TONE = 3 for 3 TICKs, then dark for 2 TICKs, then a single PB_DONE pulse.
- Send EV_REQ (kind 1) 1 TICK into a playback slot → PB_DONE pulses immediately. Then LED alternates 4'hF/0 with TONE 6/0 for 6 steps, followed by EV_DONE.
- Send EC_REQ colour 0, then EC_REQ colour 3 mid-ON → LED switches to 4'b1000 and the ON phase restarts for the full ECHO_TICKS.
- Send EV, EC and PB requests in the same cycle → win animation, then the echo slot, then the playback slot. Exactly one PB_DONE and one EV_DONE.
- Win animation → LED sequence 1, 2, 4, 8, 1, 2, 4, 8 with TONE = 5 throughout, then EV_DONE, then BUSY = 0.
- Assert RST_N mid-GAP → all outputs are 0 asynchronously. No DONE pulse after release, and the block is in IDLE.
